// File: rtl/jtkiwi_colmix.sv
// jtkiwi_colmix: tilemap/sprite priority mix, two-byte palette fetch and blank-aligned RGB output
module jtkiwi_colmix #(
  parameter int BLANK_DLY = 2
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       pxl_cen,
  input  logic       preLHBL,
  input  logic       preLVBL,
  input  logic [8:0] tm_pxl,
  input  logic [8:0] obj_pxl,
  output logic [9:0] pal_addr,
  input  logic [7:0] pal_data,
  input  logic [3:0] gfx_en,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue,
  output logic       LHBL,
  output logic       LVBL
);
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RD_DONE} state_t;
  state_t st;
  logic [8:0] sel, sel_r;
  logic [7:0] lo;
  logic [14:0] col;
  logic [BLANK_DLY-1:0] hsh, vsh;
  logic [BLANK_DLY:0] hx, vx;
  logic obj_on, tm_on, show, unused;
  assign unused = ^{gfx_en[3:2], pal_data[7]};
  assign LHBL = hsh[BLANK_DLY-1];
  assign LVBL = vsh[BLANK_DLY-1];
  always_comb begin
    obj_on = gfx_en[1] && obj_pxl[3:0] != 4'd0;
    tm_on  = gfx_en[0] && tm_pxl[3:0] != 4'd0;
    sel    = obj_on ? obj_pxl : tm_on ? tm_pxl : 9'h000;
    hx     = {hsh, preLHBL};
    vx     = {vsh, preLVBL};
    // blank state that the outputs take on this update, so RGB and LHBL/LVBL stay aligned
    show   = hx[BLANK_DLY-1] & vx[BLANK_DLY-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      sel_r <= '0;
      pal_addr <= '0;
      lo <= '0;
      col <= '0;
      hsh <= '0;
      vsh <= '0;
      {red, green, blue} <= '0;
    end else if (pxl_cen) begin
      sel_r <= sel;
      pal_addr <= {sel, 1'b0};
      st <= RD_LO;
      hsh <= hx[BLANK_DLY-1:0];
      vsh <= vx[BLANK_DLY-1:0];
      {red, green, blue} <= show ? col : 15'd0;
    end else begin
      case (st)
        RD_LO: begin
          pal_addr <= {sel_r, 1'b1};
          st <= RD_HI;
        end
        RD_HI: begin
          lo <= pal_data;
          st <= RD_DONE;
        end
        RD_DONE: begin
          col <= {pal_data[6:0], lo};
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtkiwi_colmix.sv
// tb_jtkiwi_colmix: table vectors, directed corner cases and random pixels against a pixel-level model
module tb_jtkiwi_colmix;
  logic rst = 0, clk = 0, pxl_cen = 0, preLHBL = 1, preLVBL = 1;
  logic [8:0] tm_pxl = 0, obj_pxl = 0;
  logic [3:0] gfx_en = 4'hf;
  logic [9:0] pal_addr;
  logic [7:0] pal_data;
  logic [4:0] red, green, blue;
  logic LHBL, LVBL;
  logic [7:0] mem [1024];
  logic [7:0] ram_q = 0;

  jtkiwi_colmix dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .preLHBL(preLHBL), .preLVBL(preLVBL),
    .tm_pxl(tm_pxl), .obj_pxl(obj_pxl), .pal_addr(pal_addr), .pal_data(pal_data),
    .gfx_en(gfx_en), .red(red), .green(green), .blue(blue), .LHBL(LHBL), .LVBL(LVBL)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[pal_addr];
  assign pal_data = ram_q;

  int checks = 0, errors = 0;
  // model of the pixel pipeline: one pending pixel, one last completed colour
  int gap = 0;
  logic [14:0] pend_col = 0, done_col = 0;
  logic pend_h = 0, pend_v = 0, hi_due = 0;
  logic [9:0] exp_hi = 0;

  typedef struct {
    logic [8:0] obj;
    logic [8:0] tm;
    logic [3:0] gfx;
    logic [9:0] addr;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] pick(input logic [8:0] o, input logic [8:0] t, input logic [3:0] g);
    if (g[1] && o[3:0] != 0) return o;
    if (g[0] && t[3:0] != 0) return t;
    return 9'h000;
  endfunction

  function automatic logic [14:0] colour(input logic [8:0] s);
    logic [7:0] l, h;
    l = mem[{s, 1'b0}];
    h = mem[{s, 1'b1}];
    return {h[6:0], l};
  endfunction

  task automatic tick(input logic cen);
    logic [8:0] s;
    @(negedge clk);
    pxl_cen = cen;
    @(posedge clk);
    #1;
    if (cen) begin
      if (gap >= 3) done_col = pend_col;
      chk("lhbl", 32'(LHBL), 32'(pend_h));
      chk("lvbl", 32'(LVBL), 32'(pend_v));
      chk("rgb", 32'({red, green, blue}), 32'((pend_h & pend_v) ? done_col : 15'd0));
      chk("no_x", 32'($isunknown({red, green, blue, LHBL, LVBL, pal_addr})), 0);
      s = pick(obj_pxl, tm_pxl, gfx_en);
      chk("addr_lo", 32'(pal_addr), 32'({s, 1'b0}));
      pend_col = colour(s);
      pend_h = preLHBL;
      pend_v = preLVBL;
      exp_hi = {s, 1'b1};
      hi_due = 1;
      gap = 0;
    end else begin
      if (hi_due) chk("addr_hi", 32'(pal_addr), 32'(exp_hi));
      hi_due = 0;
      gap++;
    end
  endtask

  task automatic pixel(input logic [8:0] o, input logic [8:0] t, input logic [3:0] g,
                       input logic h, input logic v, input int period);
    obj_pxl = o; tm_pxl = t; gfx_en = g; preLHBL = h; preLVBL = v;
    tick(1);
    repeat (period - 1) tick(0);
  endtask

  task automatic model_reset();
    gap = 0; pend_col = 0; done_col = 0; pend_h = 0; pend_v = 0; hi_due = 0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rgb"}, 32'({red, green, blue}), 0);
    chk({name, "_addr"}, 32'(pal_addr), 0);
    chk({name, "_blank"}, 32'({LHBL, LVBL}), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h04A] = 8'h1F;
    mem[10'h04B] = 8'h7C;
    vecs[0] = '{9'h025, 9'h013, 4'hf, 10'h04A};
    vecs[1] = '{9'h030, 9'h013, 4'hf, 10'h026};
    vecs[2] = '{9'h025, 9'h000, 4'h1, 10'h000};
    vecs[3] = '{9'h025, 9'h013, 4'h2, 10'h04A};
    vecs[4] = '{9'h010, 9'h020, 4'hf, 10'h000};
    vecs[5] = '{9'h1F1, 9'h013, 4'hf, 10'h3E2};
    vecs[6] = '{9'h025, 9'h013, 4'h1, 10'h026};

    rst = 1;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 0;
    model_reset();

    // priority example held for two pixels, explicit colour from the plan
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 4);
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 4);
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 4);
    chk("plan_red", 32'(red), 31);
    chk("plan_green", 32'(green), 0);
    chk("plan_blue", 32'(blue), 31);

    foreach (vecs[i]) begin
      obj_pxl = vecs[i].obj; tm_pxl = vecs[i].tm; gfx_en = vecs[i].gfx;
      preLHBL = 1; preLVBL = 1;
      tick(1);
      chk($sformatf("tbl%0d_lo", i), 32'(pal_addr), 32'(vecs[i].addr));
      tick(0);
      chk($sformatf("tbl%0d_hi", i), 32'(pal_addr), 32'(vecs[i].addr | 10'd1));
      tick(0);
      tick(0);
    end

    // one blanked pixel between visible ones
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 5);
    pixel(9'h025, 9'h013, 4'hf, 0, 1, 5);
    chk("blank_pre_lhbl", 32'(LHBL), 1);
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 5);
    chk("blank_lhbl_low", 32'(LHBL), 0);
    chk("blank_rgb_zero", 32'({red, green, blue}), 0);
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 5);
    chk("blank_lhbl_back", 32'(LHBL), 1);
    chk("blank_rgb_back", 32'({red, green, blue}), 32'(15'h7C1F));

    // short periods: sequences restart, colour repeats
    for (int i = 0; i < 6; i++) pixel(9'($urandom), 9'($urandom), 4'hf, 1, 1, 2);
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 3);
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 4);

    // reset while the fetch sits in RD_HI
    obj_pxl = 9'h1F1;
    tick(1);
    tick(0);
    @(negedge clk);
    rst = 1;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst = 0;
    model_reset();
    pixel(9'h025, 9'h013, 4'hf, 1, 1, 4);
    chk("post_rst_first", 32'({red, green, blue}), 0);
    pixel(9'h030, 9'h013, 4'hf, 1, 1, 4);
    chk("post_rst_second", 32'({red, green, blue}), 32'(15'h7C1F));

    for (int i = 0; i < 200; i++) begin
      logic [8:0] o, t;
      int p;
      o = 9'($urandom);
      t = 9'($urandom);
      if ($urandom_range(0, 3) == 0) o[3:0] = 0;
      if ($urandom_range(0, 3) == 0) t[3:0] = 0;
      p = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(4, 6));
      pixel(o, t, 4'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtkiwi_colmix.md
Name: jtkiwi_colmix

Overview:
- Final pixel stage, directly downstream of the tilemap and sprite line buffers.
- Each pixel period it takes the 9-bit tilemap pixel and the 9-bit sprite pixel and picks one by transparency and priority.
- It fetches the 16-bit colour for the chosen pixel as two sequential byte reads from an 8-bit palette RAM.
- Outputs are 5-bit RGB plus blanking signals, aligned to the fetch latency.

Parameters:
- BLANK_DLY, 2, number of pxl_cen periods by which LHBL/LVBL are delayed to match the colour latency.

Ports:
- rst  input  1  asynchronous reset, active high
- clk  input  1  system clock; the only clock
- pxl_cen  input  1  pixel clock enable; period of 4 or more clk cycles
- preLHBL  input  1  horizontal blank from the timing generator, active low
- preLVBL  input  1  vertical blank from the timing generator, active low
- tm_pxl  input  9  tilemap pixel: [8:4] palette, [3:0] colour index
- obj_pxl  input  9  sprite pixel, same format as tm_pxl
- pal_addr  output  10  palette RAM byte address
- pal_data  input  8  palette RAM read data; valid one clk after pal_addr
- gfx_en  input  4  layer enables: bit0 = tilemap, bit1 = sprites
- red  output  5  red component
- green  output  5  green component
- blue  output  5  blue component
- LHBL  output  1  delayed horizontal blank
- LVBL  output  1  delayed vertical blank

Behaviour:
- Reset: state IDLE; pal_addr, red, green and blue = 0; LHBL and LVBL = 0; all internal delay lines cleared.
- Transparency: a pixel is transparent when bits [3:0] = 0. A layer whose gfx_en bit is 0 is also treated as transparent.
- Priority:
  - Sprite wins when it is not transparent.
  - Otherwise the tilemap pixel is used if it is not transparent.
  - Otherwise the value is 9'h000 (the backdrop, palette entry 0).
- Selection happens on the clk edge where pxl_cen = 1; the selected value is latched as sel[8:0].
- State machine (advances every clk; only pxl_cen starts a sequence):
  - IDLE: on pxl_cen, latch sel, set pal_addr = {sel,0}, go to RD_LO.
  - RD_LO: set pal_addr = {sel,1}, go to RD_HI.
  - RD_HI: latch pal_data as lo_byte, go to RD_DONE.
  - RD_DONE: latch pal_data as hi_byte, set col_word = {hi_byte, lo_byte}, go to IDLE.
- Colour decode: red = col_word[14:10], green = col_word[9:5], blue = col_word[4:0]. Bit 15 is ignored.
- Output update:
  - red, green and blue update only on pxl_cen, loading col_word as completed by the previous sequence.
  - Total latency is 2 pxl_cen periods from tm_pxl/obj_pxl sampling to RGB output.
- Blanking:
  - preLHBL and preLVBL pass through a BLANK_DLY-stage shift register clocked on pxl_cen.
  - When the delayed LHBL or LVBL is 0 at the output update, red, green and blue are forced to 0 instead of the decoded colour.
- pxl_cen arriving in any state other than IDLE: the sequence restarts from the new pixel as if the state were IDLE. The incomplete col_word is not updated, so the next output update repeats the previous colour. No error flag is raised.
- pal_addr holds its last value in IDLE. Reads are side-effect free.
- Reset asserted mid-sequence: the state returns to IDLE immediately and outputs return to their reset values. The first valid colour appears 2 pxl_cen periods after reset release.

Test Plan:
- Priority: obj_pxl = 9'h025, tm_pxl = 9'h013, gfx_en = 4'hf, pixel held for 2 pxl_cen. Required: pal_addr sequence 10'h04A then 10'h04B. With RAM[04A] = 8'h1F and RAM[04B] = 8'h7C, the output is red = 31, green = 0, blue = 31.
- Transparency fall-through: obj_pxl = 9'h030 (index 0), tm_pxl = 9'h013. Required: pal_addr = 10'h026 then 10'h027.
- Layer disable: gfx_en = 4'h1 with obj_pxl = 9'h025 and tm_pxl = 9'h000. Required: backdrop is used, pal_addr = 10'h000 then 10'h001.
- Blanking: drive preLHBL = 0 for one pixel. Required: LHBL goes low exactly 2 pxl_cen later, and RGB = 0 for that pixel only.
- Short period: pxl_cen period of 2 clk. Required: the FSM restarts on each pxl_cen, RGB holds its prior value, and no X appears on any output.
- Mid-operation reset: assert rst while in RD_HI. Required: state = IDLE, all outputs = 0 within the same cycle; after release, valid RGB appears on the 2nd pxl_cen.
